hs_rx_responder: RTL

HS_RX_RESPONDER -- requirements
Module: hs_rx_responder

---
 rtl/hs_rx_responder_if.sv | 29 ++
 rtl/hs_rx_responder.sv | 105 ++++++++++
 2 files changed

// File: rtl/hs_rx_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : hs_rx_responder_if
//  Brief    : Transmitter-side handshake and consumer-side buffer signals.
//  Revision : 1.0 - initial release
// ============================================================================
interface hs_rx_responder_if #(
  parameter int WIDTH = 32
);
  logic             req_in;
  logic [WIDTH-1:0] data_in;
  logic             ack;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      xfer_cnt;
  logic             proto_err;

  modport master (
    output req_in, data_in, out_ready,
    input  ack, data_out, out_valid, xfer_cnt, proto_err
  );

  modport slave (
    input  req_in, data_in, out_ready,
    output ack, data_out, out_valid, xfer_cnt, proto_err
  );
endinterface
`default_nettype wire

// File: rtl/hs_rx_responder.sv
`default_nettype none
// ============================================================================
//  Module   : hs_rx_responder
//  Brief    : Four-phase request/ack receiver with one-word output buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module hs_rx_responder #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2    // must be at least 2
) (
  input  wire logic          clk,
  input  wire logic          rst,
  hs_rx_responder_if.slave   io
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t             r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic               r_ack;
  logic [WIDTH-1:0]   r_data_out;
  logic               r_out_valid;
  logic [15:0]        r_xfer_cnt;
  logic               r_proto_err;

  logic w_req_s;
  logic w_free;
  logic w_pop;
  logic w_capture;

  assign w_req_s = r_sync[SYNC_STAGES-1];
  assign w_pop   = r_out_valid && io.out_ready;
  // A pop in the same cycle frees the slot for an incoming word.
  assign w_free  = !r_out_valid || io.out_ready;
  assign w_capture = w_req_s && w_free &&
                     ((r_state == ST_IDLE) || (r_state == ST_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync      <= '0;
      r_state     <= ST_IDLE;
      r_ack       <= 1'b0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_xfer_cnt  <= 16'h0000;
      r_proto_err <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], io.req_in};

      if (w_pop) begin
        r_out_valid <= 1'b0;
      end
      if (w_capture) begin
        r_data_out  <= io.data_in;
        r_out_valid <= 1'b1;
        r_xfer_cnt  <= r_xfer_cnt + 16'h0001;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_req_s) begin
            if (w_free) begin
              r_state <= ST_ACK;
              r_ack   <= 1'b1;
            end else begin
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // Withdrawal wins over a buffer that frees in the same cycle.
          if (!w_req_s) begin
            r_state     <= ST_IDLE;
            r_proto_err <= 1'b1;
          end else if (w_free) begin
            r_state <= ST_ACK;
            r_ack   <= 1'b1;
          end
        end
        ST_ACK: begin
          if (!w_req_s) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign io.ack       = r_ack;
  assign io.data_out  = r_data_out;
  assign io.out_valid = r_out_valid;
  assign io.xfer_cnt  = r_xfer_cnt;
  assign io.proto_err = r_proto_err;

endmodule
`default_nettype wire
